// File: rtl/uart_clk_en.sv
// Baud enable: one-cycle registered pulse every DIV clocks (DIV = CLK_HZ/BAUD rounded to nearest).
// Latency: en is registered, so it follows cnt by one clock. No backpressure: the counter runs freely.
module uart_clk_en #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic en
);

  // Guard the divisor so a zero BAUD reaches the parameter check below instead of a divide-by-zero.
  localparam int DIV = (CLK_HZ + BAUD / 2) / ((BAUD > 0) ? BAUD : 1);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (BAUD <= 0) begin : g_bad_baud
    $error("uart_clk_en: BAUD must be > 0");
  end
  if (CLK_HZ <= 0) begin : g_bad_clk
    $error("uart_clk_en: CLK_HZ must be > 0");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_clk_en: DIV must be >= 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;

  // The wrap is an explicit compare, so the counter is correct for non-power-of-two DIV.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    en_d  = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      en_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign en = en_q;

endmodule

// File: tb/tb_uart_clk_en.sv
// Directed checks of uart_clk_en: default rate, DIV=10 with reset mid-count and mid-pulse, DIV=3.
module tb_uart_clk_en;

  logic clk = 1'b0;
  logic rst_def, rst10, rst3;
  logic en_def, en10, en3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_clk_en u_def (.clk(clk), .reset(rst_def), .en(en_def));
  uart_clk_en #(.CLK_HZ(1_000_000), .BAUD(100_000)) u_d10 (.clk(clk), .reset(rst10), .en(en10));
  uart_clk_en #(.CLK_HZ(1_000_000), .BAUD(300_000)) u_d3  (.clk(clk), .reset(rst3),  .en(en3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    int k;
    int base10;
    int rel;
    int highs10, highs3, highs_def;
    int first_k, second_k;
    time first_t, second_t;
    logic prev_def;

    highs10 = 0; highs3 = 0; highs_def = 0;
    first_k = 0; second_k = 0; first_t = 0; second_t = 0;
    base10 = 0; prev_def = 1'b0;

    rst_def = 1'b1; rst10 = 1'b1; rst3 = 1'b1;
    #2;
    rst_def = 1'b0; rst10 = 1'b0; rst3 = 1'b0;
    #2;
    chk("rst_en_def", {31'b0, en_def}, 32'd0);
    chk("rst_en10",   {31'b0, en10},   32'd0);
    chk("rst_en3",    {31'b0, en3},    32'd0);
    chk("rst_cnt10",  32'(u_d10.cnt_q), 32'd0);
    #4;
    rst_def = 1'b1; rst10 = 1'b1; rst3 = 1'b1;

    // Edge k is the k-th rising edge after release (first at t=15).
    for (k = 1; k <= 10420; k++) begin
      @(posedge clk);
      @(negedge clk);

      if (en_def && !prev_def) begin
        highs_def++;
        if (highs_def == 1) begin first_k = k; first_t = $time; end
        if (highs_def == 2) begin second_k = k; second_t = $time; end
      end
      if (en_def && prev_def) chk("def_double_high", 32'd1, 32'd0);
      prev_def = en_def;

      if (k <= 30) begin
        chk("d3_en", {31'b0, en3}, (k % 3 == 0) ? 32'd1 : 32'd0);
        if (en3) highs3++;
      end

      if (k <= 150) begin
        if ((k >= 106 && k <= 108) || k == 129) begin
          chk("d10_rst_hold_en",  {31'b0, en10},  32'd0);
          chk("d10_rst_hold_cnt", 32'(u_d10.cnt_q), 32'd0);
        end else begin
          rel = k - base10;
          chk("d10_en",  {31'b0, en10},  (rel % 10 == 0) ? 32'd1 : 32'd0);
          chk("d10_cnt", 32'(u_d10.cnt_q), 32'(rel % 10));
          if (k <= 100 && en10) highs10++;
        end

        if (k == 105) begin
          rst10 = 1'b0;
          #1;
          chk("d10_midcnt_en",  {31'b0, en10},  32'd0);
          chk("d10_midcnt_cnt", 32'(u_d10.cnt_q), 32'd0);
        end
        if (k == 108) begin
          rst10 = 1'b1;
          base10 = 108;
        end
        if (k == 128) begin
          rst10 = 1'b0;
          #1;
          chk("d10_midpulse_en", {31'b0, en10}, 32'd0);
        end
        if (k == 129) begin
          rst10 = 1'b1;
          base10 = 129;
        end
        if (k == 100) chk("d10_pulse_count", 32'(highs10), 32'd10);
      end
    end

    chk("d3_pulse_count",  32'(highs3),    32'd10);
    chk("def_first_edge",  32'(first_k),   32'd5208);
    chk("def_second_edge", 32'(second_k),  32'd10416);
    chk("def_spacing_ns",  32'(second_t - first_t), 32'd52080);
    chk("def_pulse_count", 32'(highs_def), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
